// File: rtl/pwm_update_ctrl_if.sv
// Configuration request bus between reg_if (master) and pwm_update_ctrl (slave).
// cfg_ready tells the master whether a cfg_wr pulse this cycle will be accepted.
interface pwm_update_ctrl_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned STEP_W = 8
);
    logic              cfg_wr;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_duty;
    logic [STEP_W-1:0] cfg_step;
    logic              cfg_ready;

    modport master (
        output cfg_wr,
        output cfg_period,
        output cfg_duty,
        output cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_wr,
        input  cfg_period,
        input  cfg_duty,
        input  cfg_step,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_update_ctrl.sv
// Validates period/duty requests, holds them in shadow registers and commits them
// to pwm_core only on period boundaries, optionally ramping duty by a fixed step.
module pwm_update_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    pwm_update_ctrl_if.slave cfg,
    input  logic             pwm_en,
    input  logic             pwm_eop,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] duty_out,
    output logic             load,
    output logic             busy,
    output logic             err_duty,
    output logic             err_ovr,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  sh_period;
    logic [CNT_W-1:0]  sh_target;
    logic [STEP_W-1:0] sh_step;

    logic              req_bad;
    logic              req_ok;
    logic              req_ovr;
    logic              commit;

    logic [CNT_W:0]    step_ext;
    logic [CNT_W:0]    up_sum;
    logic [CNT_W:0]    dn_diff;
    logic [CNT_W-1:0]  ramp_duty;
    logic [CNT_W-1:0]  next_duty;

    logic              upd;
    logic [CNT_W-1:0]  duty_nxt;

    assign cfg.cfg_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    assign req_bad = (state == IDLE) && cfg.cfg_wr && (cfg.cfg_duty > cfg.cfg_period);
    assign req_ok  = (state == IDLE) && cfg.cfg_wr && (cfg.cfg_duty <= cfg.cfg_period);
    assign req_ovr = (state != IDLE) && cfg.cfg_wr;
    assign commit  = (pwm_en && pwm_eop) || !pwm_en;

    // One ramp step toward the target in CNT_W+1 bits, then clamped to the new period.
    always_comb begin
        step_ext = (CNT_W+1)'(sh_step);
        up_sum   = {1'b0, duty_out} + step_ext;
        dn_diff  = {1'b0, duty_out} - step_ext;
        if (sh_step == '0) begin
            ramp_duty = sh_target;
        end else if (duty_out < sh_target) begin
            ramp_duty = (up_sum >= {1'b0, sh_target}) ? sh_target : up_sum[CNT_W-1:0];
        end else if (dn_diff[CNT_W] || (dn_diff[CNT_W-1:0] <= sh_target)) begin
            ramp_duty = sh_target;
        end else begin
            ramp_duty = dn_diff[CNT_W-1:0];
        end
        next_duty = (ramp_duty > sh_period) ? sh_period : ramp_duty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_ok) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (commit) begin
                    state_nxt = (next_duty == sh_target) ? IDLE : RAMP;
                end
            end
            RAMP: begin
                if (!pwm_en) begin
                    state_nxt = IDLE;
                end else if (pwm_eop) begin
                    state_nxt = (next_duty == sh_target) ? IDLE : RAMP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd      = 1'b0;
        duty_nxt = duty_out;
        unique case (state)
            PEND: begin
                if (commit) begin
                    upd      = 1'b1;
                    duty_nxt = next_duty;
                end
            end
            RAMP: begin
                if (!pwm_en) begin
                    upd      = 1'b1;
                    duty_nxt = sh_target;
                end else if (pwm_eop) begin
                    upd      = 1'b1;
                    duty_nxt = next_duty;
                end
            end
            default: begin
                upd      = 1'b0;
                duty_nxt = duty_out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period  <= '0;
            sh_target  <= '0;
            sh_step    <= '0;
            period_out <= '0;
            duty_out   <= '0;
            load       <= 1'b0;
        end else begin
            load <= upd;
            if (req_ok) begin
                sh_period <= cfg.cfg_period;
                sh_target <= cfg.cfg_duty;
                sh_step   <= cfg.cfg_step;
            end
            if (upd) begin
                period_out <= sh_period;
                duty_out   <= duty_nxt;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the sticky bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_duty <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            if (req_bad) begin
                err_duty <= 1'b1;
            end else if (err_clr) begin
                err_duty <= 1'b0;
            end
            if (req_ovr) begin
                err_ovr <= 1'b1;
            end else if (err_clr) begin
                err_ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed bench for pwm_update_ctrl: every load pulse is checked against a queue of
// expected commits; state/error flags are checked directly between steps.
module tb_pwm_update_ctrl;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned STEP_W = 8;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
        logic             busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_en;
    logic             pwm_eop;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] duty_out;
    logic             load;
    logic             busy;
    logic             err_duty;
    logic             err_ovr;
    logic             err_clr;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    pwm_update_ctrl_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) cfg_bus ();

    pwm_update_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_bus),
        .pwm_en     (pwm_en),
        .pwm_eop    (pwm_eop),
        .period_out (period_out),
        .duty_out   (duty_out),
        .load       (load),
        .busy       (busy),
        .err_duty   (err_duty),
        .err_ovr    (err_ovr),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eop_pulse();
        pwm_eop = 1'b1;
        tick();
        pwm_eop = 1'b0;
    endtask

    task automatic request(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d,
                           input logic [STEP_W-1:0] s);
        cfg_bus.cfg_wr     = 1'b1;
        cfg_bus.cfg_period = p;
        cfg_bus.cfg_duty   = d;
        cfg_bus.cfg_step   = s;
        tick();
        cfg_bus.cfg_wr     = 1'b0;
    endtask

    task automatic expect_load(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d,
                               input logic b);
        exp_t e;
        e.period = p;
        e.duty   = d;
        e.busy   = b;
        sb.push_back(e);
    endtask

    // Monitor: every load strobe must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && load) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: period=%0d duty=%0d, expected no load",
                         period_out, duty_out);
            end else begin
                e = sb.pop_front();
                chk("load_period", 32'(period_out), 32'(e.period));
                chk("load_duty",   32'(duty_out),   32'(e.duty));
                chk("load_busy",   32'(busy),       32'(e.busy));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        pwm_en             = 1'b0;
        pwm_eop            = 1'b0;
        err_clr            = 1'b0;
        cfg_bus.cfg_wr     = 1'b0;
        cfg_bus.cfg_period = '0;
        cfg_bus.cfg_duty   = '0;
        cfg_bus.cfg_step   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_period", 32'(period_out), 0);
        chk("rst_duty",   32'(duty_out),   0);
        chk("rst_load",   32'(load),       0);
        chk("rst_busy",   32'(busy),       0);
        chk("rst_ready",  32'(cfg_bus.cfg_ready), 1);
        chk("rst_errd",   32'(err_duty),   0);
        chk("rst_erro",   32'(err_ovr),    0);

        // 1: immediate update waits for the period boundary
        pwm_en = 1'b1;
        request(100, 40, 0);
        chk("t1_busy",  32'(busy), 1);
        chk("t1_ready", 32'(cfg_bus.cfg_ready), 0);
        expect_load(100, 40, 0);
        repeat (4) tick();
        chk("t1_wait_duty", 32'(duty_out), 0);
        eop_pulse();
        tick();
        chk("t1_idle_ready", 32'(cfg_bus.cfg_ready), 1);
        chk("t1_load_low",   32'(load), 0);

        // 2: ramp up 40 -> 70 by 10
        request(100, 70, 10);
        expect_load(100, 50, 1);
        expect_load(100, 60, 1);
        expect_load(100, 70, 0);
        repeat (3) begin
            eop_pulse();
            tick();
        end
        chk("t2_ready", 32'(cfg_bus.cfg_ready), 1);

        // 3: duty > period rejected
        request(50, 60, 0);
        chk("t3_errd",   32'(err_duty), 1);
        chk("t3_ready",  32'(cfg_bus.cfg_ready), 1);
        chk("t3_period", 32'(period_out), 100);
        chk("t3_duty",   32'(duty_out), 70);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_errd_clr", 32'(err_duty), 0);

        // 4: period shrink clamps duty, then ramp down
        request(100, 90, 0);
        expect_load(100, 90, 0);
        eop_pulse();
        tick();
        request(30, 10, 5);
        expect_load(30, 30, 1);
        expect_load(30, 25, 1);
        expect_load(30, 20, 1);
        expect_load(30, 15, 1);
        expect_load(30, 10, 0);
        repeat (5) begin
            eop_pulse();
            tick();
        end
        chk("t4_ready", 32'(cfg_bus.cfg_ready), 1);

        // 5: overrun during ramp, error priority over clear, pwm_en drop finishes ramp
        request(100, 80, 20);
        expect_load(100, 30, 1);
        expect_load(100, 50, 1);
        expect_load(100, 70, 1);
        expect_load(100, 80, 0);
        eop_pulse();
        tick();
        eop_pulse();
        tick();
        request(5, 1, 0);
        chk("t5_erro",  32'(err_ovr), 1);
        chk("t5_busy",  32'(busy), 1);
        err_clr = 1'b1;
        request(5, 1, 0);
        chk("t5_erro_wins", 32'(err_ovr), 1);
        tick();
        err_clr = 1'b0;
        chk("t5_erro_clr", 32'(err_ovr), 0);
        eop_pulse();
        tick();
        pwm_en = 1'b0;
        tick();
        pwm_en = 1'b1;
        chk("t5_final_duty", 32'(duty_out), 80);
        chk("t5_ready",      32'(cfg_bus.cfg_ready), 1);
        tick();

        // 6: accepted request with err_clr, then reset mid-ramp
        request(10, 20, 0);
        chk("t6_errd", 32'(err_duty), 1);
        err_clr = 1'b1;
        request(100, 20, 10);
        err_clr = 1'b0;
        chk("t6_errd_clr", 32'(err_duty), 0);
        chk("t6_busy",     32'(busy), 1);
        expect_load(100, 70, 1);
        eop_pulse();
        tick();
        request(1, 0, 0);
        chk("t6_erro", 32'(err_ovr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_period", 32'(period_out), 0);
        chk("t6_rst_duty",   32'(duty_out), 0);
        chk("t6_rst_busy",   32'(busy), 0);
        chk("t6_rst_ready",  32'(cfg_bus.cfg_ready), 1);
        chk("t6_rst_erro",   32'(err_ovr), 0);
        eop_pulse();
        chk("t6_no_load", 32'(load), 0);
        chk("t6_duty_0",  32'(duty_out), 0);
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
